// File: rtl/hack_pkg.sv
// Shared Hack definitions: machine word width and the program loader state set.
package hack_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DAT_HI,
    DAT_LO,
    RUN,
    ERR
  } loader_state_e;

  function automatic logic is_loading(loader_state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DAT_HI) || (s == DAT_LO);
  endfunction

endpackage

// File: rtl/hack_boot_loader.sv
// Byte-stream program loader for the Hack CPU: length-prefixed big-endian words
// are written to instruction memory from address 0 while the CPU is held in reset.
module hack_boot_loader
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              cpu_reset,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_din,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IDX_W  = ADDR_W + 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [63:0] CAP    = 64'd1 << ADDR_W;
  localparam logic [IDLE_W-1:0] TIMEOUT_M1 = IDLE_W'(TIMEOUT - 1);

  loader_state_e     state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [WORD_W-1:0] rom_din_q, rom_din_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              accept;
  logic [15:0]       len_w;

  assign rx_ready = !reset && is_loading(state_q);
  assign accept   = rx_ready && rx_valid;
  assign len_w    = {hi_q, rx_data};

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    len_d      = len_q;
    idx_d      = idx_q;
    idle_d     = idle_q;
    rom_we_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_din_d  = rom_din_q;

    case (state_q)
      LEN_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          if (len_w == 16'd0) begin
            state_d = RUN;
          end else if ({48'd0, len_w} > CAP) begin
            state_d = ERR;
          end else begin
            len_d   = IDX_W'(len_w);
            idx_d   = '0;
            state_d = DAT_HI;
          end
        end
      end
      DAT_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          state_d = DAT_LO;
        end
      end
      DAT_LO: begin
        if (accept) begin
          rom_we_d   = 1'b1;
          rom_addr_d = idx_q[ADDR_W-1:0];
          rom_din_d  = {hi_q, rx_data};
          idx_d      = idx_q + 1'b1;
          state_d    = (idx_q == len_q - 1'b1) ? RUN : DAT_HI;
        end
      end
      RUN, ERR: begin
        if (load_req) begin
          state_d = LEN_HI;
        end
      end
      default: state_d = LEN_HI;
    endcase

    // Idle timer runs only once a stream has started; LEN_HI waits forever.
    if (state_q == LEN_LO || state_q == DAT_HI || state_q == DAT_LO) begin
      if (accept) begin
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
        if (idle_q == TIMEOUT_M1) begin
          state_d = ERR;
        end
      end
    end else begin
      idle_d = '0;
    end

    // Registering "stayed in RUN" delays the CPU release one cycle past the last write.
    cpu_reset_d = !(state_q == RUN && state_d == RUN);
    busy_d      = cpu_reset_d;
    err_d       = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LEN_HI;
      hi_q        <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      idle_q      <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_din_q   <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      idle_q      <= idle_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_din_q   <= rom_din_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_din   = rom_din_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_hack_boot_loader.sv
// Randomized cycle-by-cycle check of hack_boot_loader against a byte-position stream model.
module tb_hack_boot_loader;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CAP     = 16;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              load_req;
  logic              cpu_reset;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_din;
  logic              busy;
  logic              err;

  hack_boot_loader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .load_req (load_req),
    .cpu_reset(cpu_reset),
    .rom_we   (rom_we),
    .rom_addr (rom_addr),
    .rom_din  (rom_din),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0 = loading, 1 = running, 2 = error; pos = bytes taken in this load.
  int          m_mode, m_pos, m_len, m_idle;
  logic [7:0]  m_hi;
  logic        e_we, e_cpu, e_busy, e_err;
  logic [31:0] e_addr, e_din;
  logic [7:0]  tx_q[$];

  function automatic bit m_ready(input bit r);
    return !r && (m_mode == 0);
  endfunction

  task automatic model_step(input bit r, input bit acc, input logic [7:0] d, input bit lr);
    int prev;
    int b;
    if (r) begin
      m_mode = 0; m_pos = 0; m_idle = 0;
      e_we = 0; e_addr = 0; e_din = 0; e_cpu = 1; e_busy = 1; e_err = 0;
      return;
    end
    prev = m_mode;
    e_we = 0;
    if (m_mode == 0) begin
      if (acc) begin
        m_idle = 0;
        if (m_pos == 0) begin
          m_hi = d; m_pos = 1;
        end else if (m_pos == 1) begin
          m_len = {m_hi, d};
          if (m_len == 0) m_mode = 1;
          else if (m_len > CAP) m_mode = 2;
          else m_pos = 2;
        end else begin
          b = m_pos - 2;
          if (b % 2 == 0) begin
            m_hi = d;
          end else begin
            e_we = 1; e_addr = b / 2; e_din = {m_hi, d};
            if (b / 2 == m_len - 1) m_mode = 1;
          end
          m_pos++;
        end
      end else if (m_pos != 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) m_mode = 2;
      end
    end else if (lr) begin
      m_mode = 0; m_pos = 0; m_idle = 0;
    end
    e_cpu  = !(prev == 1 && m_mode == 1);
    e_busy = e_cpu;
    e_err  = (m_mode == 2);
  endtask

  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit lr, output bit acc);
    reset = r; rx_valid = v; rx_data = d; load_req = lr;
    #1;
    check("rx_ready", rx_ready, m_ready(r));
    acc = v && m_ready(r);
    model_step(r, acc, d, lr);
    @(posedge clk);
    @(negedge clk);
    check("rom_we", rom_we, e_we);
    check("rom_addr", rom_addr, e_addr);
    check("rom_din", rom_din, e_din);
    check("cpu_reset", cpu_reset, e_cpu);
    check("busy", busy, e_busy);
    check("err", err, e_err);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 0, acc);
  endtask

  task automatic pulse_load_req();
    bit acc;
    cycle(0, 0, 8'h00, 1, acc);
  endtask

  task automatic push_word(input logic [15:0] w);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  task automatic make_load(input int n);
    tx_q.delete();
    push_word(16'(n));
    for (int i = 0; i < n; i++) push_word(16'($urandom));
  endtask

  // Gaps stay below TIMEOUT; noise adds load_req pulses that must be ignored.
  task automatic send(input int max_gap, input bit noise);
    bit acc;
    int gap;
    while (tx_q.size() != 0) begin
      gap = (max_gap == 0) ? 0 : $urandom_range(0, max_gap);
      for (int i = 0; i < gap; i++)
        cycle(0, 0, 8'h00, noise && ($urandom_range(0, 5) == 0), acc);
      cycle(0, 1, tx_q[0], noise && ($urandom_range(0, 5) == 0), acc);
      if (!acc) begin
        tx_q.delete();
        return;
      end
      void'(tx_q.pop_front());
    end
  endtask

  initial begin
    bit acc;
    int n;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; load_req = 1'b0;
    m_mode = 0; m_pos = 0; m_len = 0; m_idle = 0; m_hi = '0;
    e_we = 0; e_addr = 0; e_din = 0; e_cpu = 1; e_busy = 1; e_err = 0;
    @(negedge clk);

    cycle(1, 1, 8'h00, 0, acc);
    cycle(1, 0, 8'h00, 0, acc);

    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send(0, 0);
    idle(4);

    pulse_load_req();
    tx_q = '{8'h00, 8'h00};
    send(2, 0);
    idle(4);

    pulse_load_req();
    tx_q = '{8'h80, 8'h01};
    send(0, 0);
    idle(5);
    pulse_load_req();

    tx_q = '{8'h00, 8'h11};
    send(1, 1);
    idle(3);
    pulse_load_req();

    make_load(CAP);
    send(3, 1);
    idle(3);

    pulse_load_req();
    tx_q = '{8'h00, 8'h01, 8'h12};
    send(0, 0);
    idle(TIMEOUT + 4);
    pulse_load_req();
    idle(100);

    make_load(5);
    while (tx_q.size() > 9) void'(tx_q.pop_back());
    send(1, 1);
    cycle(1, 1, 8'hEE, 0, acc);
    make_load(4);
    send(0, 0);
    idle(2);

    cycle(0, 1, 8'h55, 1, acc);
    make_load(3);
    send(2, 1);
    idle(2);

    for (int k = 0; k < 8; k++) begin
      if (m_mode != 0) pulse_load_req();
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(CAP + 1, 16'hFFFF) : $urandom_range(1, CAP);
      if (n > CAP) begin
        tx_q.delete();
        push_word(16'(n));
      end else begin
        make_load(n);
      end
      send(3, 1);
      idle($urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_boot_loader.md
# hack_boot_loader

Program loader and run controller for the Hack CPU. It receives a program as a byte stream (valid/ready, e.g. from a UART RX), assembles big-endian 16-bit words and writes them into instruction ROM/RAM from address 0, holding the CPU in reset throughout. When the program is complete it releases the CPU. A `load_req` pulse later re-enters loading.

## Interface
- `ADDR_W`, default 15: instruction memory address width, giving a capacity of 2^ADDR_W words.
- `TIMEOUT`, default 1_000_000: maximum number of idle cycles allowed between accepted bytes while loading.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the loader accepts a byte this cycle.
- `load_req` in 1: single-cycle request to reload the program.
- `cpu_reset` out 1: drives the CPU `reset` input.
- `rom_we` out 1: instruction memory write strobe.
- `rom_addr` out ADDR_W: instruction memory write address.
- `rom_din` out 16: instruction memory write data.
- `busy` out 1: loader is not in RUN.
- `err` out 1: sticky error flag; cleared by `load_req` or `reset`.

## Operation
- Stream format:
  - Length N first: high byte, then low byte.
  - Then N words, each sent as high byte then low byte.
- A byte is accepted on any cycle where `rx_valid && rx_ready`.
- States:
  - LEN_HI, LEN_LO: receive the length.
  - DAT_HI, DAT_LO: receive data words.
  - RUN: CPU running.
  - ERR: load aborted.
- Transitions:
  - `reset` → LEN_HI.
  - LEN_HI → LEN_LO on accept.
  - LEN_LO on accept:
    - N=0 → RUN.
    - N > 2^ADDR_W → ERR.
    - otherwise → DAT_HI, with word index cleared to 0.
  - DAT_HI → DAT_LO on accept; the high byte is latched.
  - DAT_LO on accept: issue a write at the current index, then go to DAT_HI, or to RUN if this was word N-1.
  - RUN → LEN_HI on `load_req`.
  - ERR → LEN_HI on `load_req`; `err` clears.
  - `load_req` in any loading state is ignored.
- `rx_ready` = 1 in LEN_HI, LEN_LO, DAT_HI and DAT_LO, except in a cycle where `reset` is high. It is 0 in RUN and ERR.
- Word index counter:
  - Width is ADDR_W+1, so N = 2^ADDR_W is legal.
  - It increments after each write and never wraps within a load.
- Idle counter:
  - Clears on every accepted byte and on entry to LEN_HI.
  - Counts in the four loading states whenever no byte is accepted.
  - Reaching TIMEOUT → ERR.
  - Exception: in LEN_HI the counter is disabled, so the loader waits indefinitely for the first byte.
- ERR: `err`=1, `cpu_reset`=1, no writes.
- Reset mid-load: the load is abandoned. Memory already written is left as is and the index restarts at 0.

## Timing
- Reset values, asserted in the cycle after `reset` is sampled high:
  - `cpu_reset`=1, `busy`=1
  - `rom_we`=0, `rom_addr`=0, `rom_din`=0
  - `err`=0
  - `rx_ready`=0 while `reset` is high, then 1.
- Writes: low byte accepted at edge t → at t+1, `rom_we`=1 for exactly one cycle, with `rom_din`={hi,lo} and `rom_addr`=index.
  - `rom_addr` and `rom_din` hold their values after the strobe until the next write.
- The maximum write rate is one word per two accepted bytes. Back-to-back bytes are accepted with no bubbles.
- `cpu_reset` and `busy` fall at t+2, where t is the accept edge of the final low byte (or of the length low byte when N=0). This is exactly one cycle after the last `rom_we`.
- `load_req` sampled in RUN at edge t → `cpu_reset`=1 and `busy`=1 at t+1; `rx_ready`=1 at t+1.
- If `load_req` and a byte arrive in the same cycle in RUN, the byte is not accepted (`rx_ready` is 0 in RUN).
- All outputs are registered except `rx_ready`, which is decoded from the state register and `reset`.

## Structure
- Shared package `hack_pkg`:
  - `WORD_W`=16.
  - Loader state enum (LEN_HI, LEN_LO, DAT_HI, DAT_LO, RUN, ERR); the CPU bench also uses it.
- A single module. The idle/timeout counter and word index are inline counters, and no sub-module is needed.

## Test plan
- After `reset`, send 00 02 12 34 AB CD back-to-back → two `rom_we` pulses (addr 0=0x1234, addr 1=0xABCD); `cpu_reset` falls one cycle after the second pulse; `busy`=0.
- Send 00 00 → no `rom_we`; `cpu_reset` falls 2 cycles after the second byte is accepted.
- Send 80 01 (N > 2^15) → `err`=1, `rx_ready`=0, `cpu_reset` stays 1. Then pulse `load_req` → `err`=0, `rx_ready`=1.
- With TIMEOUT=16, send 00 01 12 and then stop → `err`=1 after 16 idle cycles, no `rom_we`. Confirm LEN_HI waits 100 cycles without error.
- Complete a load, pulse `load_req` in RUN → `cpu_reset`=1 next cycle; a new load writes from address 0. A `load_req` pulse during the new load is ignored.
- Assert `reset` between the high and low byte of word 3 → `cpu_reset`=1; a fresh stream rewrites from addr 0 with correct data.
